// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit: FSM state encoding, default
//   access latency and the latency-counter width.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    // Default access latency in cycles (legal range 1..15).
    localparam int kLsuLat = 2;

    // Counter width that covers the full latency range.
    localparam int kCntW = 4;

endpackage : load_store_unit_pkg

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Request/response bundle between the core (master) and the load/store
//   unit (slave).
//   Request : ReqValid/ReqReady handshake with ReqWrite, ReqAddr, ReqWData,
//             ReqRtaddr.
//   Response: RspValid/RspReady handshake with RspData, RspRtaddr.
//   Status  : StoreDone (one-cycle store commit pulse), Busy.
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int W  = 8,
    parameter int A  = 8,
    parameter int RA = 4
) ();
    import load_store_unit_pkg::*;

    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [A-1:0]  ReqAddr;
    logic [W-1:0]  ReqWData;
    logic [RA-1:0] ReqRtaddr;
    logic          RspValid;
    logic          RspReady;
    logic [W-1:0]  RspData;
    logic [RA-1:0] RspRtaddr;
    logic          StoreDone;
    logic          Busy;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqRtaddr, RspReady,
        input  ReqReady, RspValid, RspData, RspRtaddr, StoreDone, Busy
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqRtaddr, RspReady,
        output ReqReady, RspValid, RspData, RspRtaddr, StoreDone, Busy
    );

endinterface : load_store_unit_if

// File: rtl/load_store_unit_lsu_mem.sv
// -----------------------------------------------------------------------------
// lsu_mem
//   Single-port data memory, W bits x 2**A words. Write is synchronous,
//   read is combinational. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write word address
//   wdata : write data
//   rdata : combinational read data at addr
// -----------------------------------------------------------------------------
module lsu_mem
    import load_store_unit_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem_q [2**A];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule : lsu_mem

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-side responder for the LOD/STR path. A request is latched on
//   acceptance, the access completes LAT edges later, stores commit straight
//   into the data memory and loads return data plus destination index on
//   the response handshake.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : slave side of load_store_unit_if (request, response, status)
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int W   = 8,
    parameter int A   = 8,
    parameter int RA  = 4,
    parameter int LAT = kLsuLat
) (
    input  logic               Clk,
    input  logic               Reset,
    load_store_unit_if.slave   bus
);

    // Counter is loaded with LAT-1 so the commit lands exactly LAT edges
    // after acceptance.
    localparam logic [kCntW-1:0] kCntInit = kCntW'(LAT - 1);
    localparam logic [kCntW-1:0] kCntOne  = kCntW'(1);

    lsu_state_t      state_q, state_d;
    logic [kCntW-1:0] cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [W-1:0]    wdata_q, wdata_d;
    logic [RA-1:0]   rtaddr_q, rtaddr_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [RA-1:0]   rsp_rtaddr_q, rsp_rtaddr_d;
    logic            store_done_q, store_done_d;
    logic            busy_q, busy_d;
    logic            mem_we_s;
    logic [W-1:0]    mem_rdata_s;

    lsu_mem #(
        .W (W),
        .A (A)
    ) u_mem (
        .clk   (Clk),
        .we    (mem_we_s),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata_s)
    );

    // Next-state and next-output logic for the request/access/response FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rtaddr_d     = rtaddr_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_rtaddr_d = rsp_rtaddr_q;
        store_done_d = 1'b0;
        busy_d       = busy_q;
        mem_we_s     = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (bus.ReqValid && req_ready_q) begin
                    write_d     = bus.ReqWrite;
                    addr_d      = bus.ReqAddr;
                    wdata_d     = bus.ReqWData;
                    rtaddr_d    = bus.ReqRtaddr;
                    cnt_d       = kCntInit;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = LSU_ACCESS;
                end else begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            LSU_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - kCntOne;
                end else if (write_q) begin
                    // Store commits on this edge; the pulse is visible for
                    // the following cycle only.
                    mem_we_s     = 1'b1;
                    store_done_d = 1'b1;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = LSU_IDLE;
                end else begin
                    rsp_data_d   = mem_rdata_s;
                    rsp_rtaddr_d = rtaddr_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = LSU_RESP;
                end
            end

            LSU_RESP: begin
                if (bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = LSU_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = LSU_IDLE;
            end
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rtaddr_q     <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_rtaddr_q <= '0;
            store_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rtaddr_q     <= rtaddr_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rtaddr_q <= rsp_rtaddr_d;
            store_done_q <= store_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ReqReady  = req_ready_q;
    assign bus.RspValid  = rsp_valid_q;
    assign bus.RspData   = rsp_data_q;
    assign bus.RspRtaddr = rsp_rtaddr_q;
    assign bus.StoreDone = store_done_q;
    assign bus.Busy      = busy_q;

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench: u0 runs with LAT=2, u1 with LAT=1 for throughput.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_q[$];

    always #5 Clk = ~Clk;

    load_store_unit_if #(.W(8), .A(8), .RA(4)) b0 ();
    load_store_unit_if #(.W(8), .A(8), .RA(4)) b1 ();

    load_store_unit #(.W(8), .A(8), .RA(4), .LAT(2)) u0 (
        .Clk (Clk), .Reset (Reset), .bus (b0)
    );

    load_store_unit #(.W(8), .A(8), .RA(4), .LAT(1)) u1 (
        .Clk (Clk), .Reset (Reset), .bus (b1)
    );

    // Edge counter plus record of the edges at which u1 accepted a request.
    always @(posedge Clk) begin
        if (b1.ReqValid && b1.ReqReady) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_store(input logic [7:0] addr, input logic [7:0] data);
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b1; b0.ReqAddr = addr; b0.ReqWData = data;
        tick();
        b0.ReqValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b0.ReqReady) break;
            tick();
        end
    endtask

    task automatic do_load(input logic [7:0] addr, input logic [3:0] rt,
                           output logic [7:0] data, output logic [3:0] rta);
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b0; b0.ReqAddr = addr; b0.ReqRtaddr = rt;
        b0.RspReady = 1'b1;
        tick();
        b0.ReqValid = 1'b0;
        data = 8'hxx; rta = 4'hx;
        for (int i = 0; i < 20; i++) begin
            if (b0.RspValid) begin
                data = b0.RspData; rta = b0.RspRtaddr;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clk);
        total++; if (b0.ReqReady !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", b0.ReqReady); end
        total++; if (b0.RspValid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", b0.RspValid); end
        total++; if (b0.RspData !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h exp=00", b0.RspData); end
        total++; if (b0.RspRtaddr !== 4'h0) begin bad++; $display("FAIL reset_rsp_rtaddr got=%h exp=0", b0.RspRtaddr); end
        total++; if (b0.StoreDone !== 1'b0) begin bad++; $display("FAIL reset_store_done got=%b exp=0", b0.StoreDone); end
        total++; if (b0.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b0.Busy); end
        Reset = 1'b0;
        tick();
        total++; if (b0.ReqReady !== 1'b1 || b0.Busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset ready=%b busy=%b exp=1/0", b0.ReqReady, b0.Busy); end
    endtask

    task automatic test_store_load();
        logic [7:0] d; logic [3:0] r;
        b0.RspReady = 1'b1;
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b1; b0.ReqAddr = 8'h10; b0.ReqWData = 8'hA5;
        tick();                                   // accept edge t0
        b0.ReqValid = 1'b0;
        total++; if (b0.Busy !== 1'b1 || b0.ReqReady !== 1'b0) begin bad++; $display("FAIL store_busy busy=%b ready=%b exp=1/0", b0.Busy, b0.ReqReady); end
        tick();                                   // t0+1
        total++; if (b0.StoreDone !== 1'b0) begin bad++; $display("FAIL store_done_early got=%b exp=0", b0.StoreDone); end
        tick();                                   // t0+2
        total++; if (b0.StoreDone !== 1'b1) begin bad++; $display("FAIL store_done_pulse got=%b exp=1", b0.StoreDone); end
        total++; if (b0.ReqReady !== 1'b1) begin bad++; $display("FAIL store_ready_back got=%b exp=1", b0.ReqReady); end
        tick();
        total++; if (b0.StoreDone !== 1'b0) begin bad++; $display("FAIL store_done_width got=%b exp=0", b0.StoreDone); end
        // load with explicit per-edge latency check
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b0; b0.ReqAddr = 8'h10; b0.ReqRtaddr = 4'd5;
        tick();                                   // t0
        b0.ReqValid = 1'b0;
        tick();                                   // t0+1
        total++; if (b0.RspValid !== 1'b0) begin bad++; $display("FAIL load_valid_early got=%b exp=0", b0.RspValid); end
        tick();                                   // t0+2
        total++; if (b0.RspValid !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", b0.RspValid); end
        total++; if (b0.RspData !== 8'hA5) begin bad++; $display("FAIL load_data got=%h exp=a5", b0.RspData); end
        total++; if (b0.RspRtaddr !== 4'd5) begin bad++; $display("FAIL load_rtaddr got=%h exp=5", b0.RspRtaddr); end
        tick();                                   // t0+3 handshake
        total++; if (b0.RspValid !== 1'b0 || b0.ReqReady !== 1'b1) begin bad++; $display("FAIL load_complete valid=%b ready=%b exp=0/1", b0.RspValid, b0.ReqReady); end
        do_load(8'h10, 4'd9, d, r);
        total++; if (d !== 8'hA5 || r !== 4'd9) begin bad++; $display("FAIL load_task got=%h/%h exp=a5/9", d, r); end
    endtask

    task automatic test_backpressure();
        b0.RspReady = 1'b0;
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b0; b0.ReqAddr = 8'h10; b0.ReqRtaddr = 4'd3;
        tick();
        b0.ReqValid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b0.RspValid !== 1'b1 || b0.RspData !== 8'hA5 || b0.RspRtaddr !== 4'd3 || b0.ReqReady !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d valid=%b data=%h rt=%h ready=%b exp=1/a5/3/0", i, b0.RspValid, b0.RspData, b0.RspRtaddr, b0.ReqReady);
            end
            tick();
        end
        b0.RspReady = 1'b1;
        tick();
        total++; if (b0.RspValid !== 1'b0 || b0.ReqReady !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", b0.RspValid, b0.ReqReady); end
    endtask

    task automatic test_ignored();
        logic [7:0] d; logic [3:0] r;
        b0.RspReady = 1'b1;
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b0; b0.ReqAddr = 8'h10; b0.ReqRtaddr = 4'd2;
        tick();                                   // load accepted
        b0.ReqWrite = 1'b1; b0.ReqWData = 8'hFF; b0.ReqAddr = 8'h10;  // ReqValid still high
        tick();
        tick();
        total++; if (b0.RspValid !== 1'b1 || b0.RspData !== 8'hA5 || b0.RspRtaddr !== 4'd2) begin bad++; $display("FAIL ign_rsp valid=%b data=%h rt=%h exp=1/a5/2", b0.RspValid, b0.RspData, b0.RspRtaddr); end
        total++; if (b0.StoreDone !== 1'b0) begin bad++; $display("FAIL ign_store_done got=%b exp=0", b0.StoreDone); end
        b0.ReqValid = 1'b0;
        tick();
        do_load(8'h10, 4'd7, d, r);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL ign_reload got=%h exp=a5", d); end
    endtask

    task automatic test_boundary();
        logic [7:0] d; logic [3:0] r;
        do_store(8'h00, 8'h01);
        do_store(8'hFF, 8'h02);
        do_load(8'h00, 4'd1, d, r);
        total++; if (d !== 8'h01 || r !== 4'd1) begin bad++; $display("FAIL bound_lo got=%h/%h exp=01/1", d, r); end
        do_load(8'hFF, 4'd15, d, r);
        total++; if (d !== 8'h02 || r !== 4'd15) begin bad++; $display("FAIL bound_hi got=%h/%h exp=02/f", d, r); end
        do_load(8'h10, 4'd0, d, r);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL bound_mid got=%h exp=a5", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic [3:0] r;
        int pulses;
        do_store(8'h20, 8'h11);
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b1; b0.ReqAddr = 8'h20; b0.ReqWData = 8'h3C;
        tick();                                   // accepted, now in ACCESS
        b0.ReqValid = 1'b0;
        Reset = 1'b1;
        #1;
        total++;
        if (b0.ReqReady !== 1'b1 || b0.Busy !== 1'b0 || b0.RspValid !== 1'b0 || b0.StoreDone !== 1'b0 || b0.RspData !== 8'h00 || b0.RspRtaddr !== 4'h0) begin
            bad++;
            $display("FAIL rst_access ready=%b busy=%b valid=%b sd=%b data=%h rt=%h", b0.ReqReady, b0.Busy, b0.RspValid, b0.StoreDone, b0.RspData, b0.RspRtaddr);
        end
        @(negedge Clk);
        Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b0.StoreDone === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rst_no_store_done got=%0d exp=0", pulses); end
        do_load(8'h20, 4'd4, d, r);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL rst_mem_kept got=%h exp=11", d); end
        // reset while a response is waiting
        b0.RspReady = 1'b0;
        b0.ReqValid = 1'b1; b0.ReqWrite = 1'b0; b0.ReqAddr = 8'h10; b0.ReqRtaddr = 4'd6;
        tick();
        b0.ReqValid = 1'b0;
        tick(); tick();
        total++; if (b0.RspValid !== 1'b1) begin bad++; $display("FAIL rst_resp_pre got=%b exp=1", b0.RspValid); end
        Reset = 1'b1;
        #1;
        total++; if (b0.RspValid !== 1'b0 || b0.RspData !== 8'h00 || b0.ReqReady !== 1'b1) begin bad++; $display("FAIL rst_resp valid=%b data=%h ready=%b exp=0/00/1", b0.RspValid, b0.RspData, b0.ReqReady); end
        @(negedge Clk);
        Reset = 1'b0;
        b0.RspReady = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int start_cyc;
        acc_q.delete();
        start_cyc = cyc;
        b1.ReqValid = 1'b1; b1.ReqWrite = 1'b0; b1.ReqAddr = 8'h00; b1.RspReady = 1'b1;
        repeat (7) tick();                        // edges start_cyc .. start_cyc+6
        b1.ReqValid = 1'b0;
        repeat (3) tick();
        total++; if (acc_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", acc_q.size()); end
        if (acc_q.size() >= 3) begin
            total++; if (acc_q[0] != start_cyc) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", acc_q[0], start_cyc); end
            total++; if (acc_q[1] != start_cyc + 3) begin bad++; $display("FAIL b2b_second got=%0d exp=%0d", acc_q[1], start_cyc + 3); end
            total++; if (acc_q[2] != start_cyc + 6) begin bad++; $display("FAIL b2b_third got=%0d exp=%0d", acc_q[2], start_cyc + 6); end
        end
    endtask

    initial begin
        Reset = 1'b1;
        b0.ReqValid = 1'b0; b0.ReqWrite = 1'b0; b0.ReqAddr = 8'h00; b0.ReqWData = 8'h00;
        b0.ReqRtaddr = 4'h0; b0.RspReady = 1'b0;
        b1.ReqValid = 1'b0; b1.ReqWrite = 1'b0; b1.ReqAddr = 8'h00; b1.ReqWData = 8'h00;
        b1.ReqRtaddr = 4'h0; b1.RspReady = 1'b0;
        test_reset();
        test_store_load();
        test_backpressure();
        test_ignored();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_load_store_unit
